vend_machine_multi: RTL and testbench
=====================================

// Module: vend_machine_multi
// PURPOSE
//  Parametrised multi-product vending controller; successor to the single-product coffee machine.
//  Accepts three coin denominations and sells up to NUM_PRODUCTS items at per-product prices.
//  Returns change as a coin stream (greedy, largest first) and supports cancel/refund.
//  Sits between the coin acceptor front-end and the dispenser/change-hopper actuators.
// PARAMETERS
//  NUM_PRODUCTS  4                  number of selectable products (1..8)
//  CREDIT_W      7                  credit register width, in value units
//  MAX_CREDIT    100                credit ceiling; must be < 2**CREDIT_W
//  COIN1_VAL     5                  value of coin code 2'd1
//  COIN2_VAL     10                 value of coin code 2'd2
//  COIN3_VAL     25                 value of coin code 2'd3
//  PRICES        {8'd30,8'd25,8'd20,8'd15}  packed 8b per product; product 0 in LSBs
//  STOCK_INIT    3                  initial per-product stock (STOCK_EN only)
// PORTS
//  clk           in   1                      system clock, rising edge
//  rst           in   1                      synchronous, active-high reset
//  coin          in   2                      0=none, 1/2/3=coin; one cycle per coin
//  sel_valid     in   1                      product selection strobe
//  sel_id        in   $clog2(NUM_PRODUCTS)   selected product
//  cancel        in   1                      refund request
//  dispense      out  1                      one-cycle vend pulse
//  dispense_id   out  $clog2(NUM_PRODUCTS)   product dispensed; valid with dispense
//  change_coin   out  2                      coin code returned this cycle; 0=none
//  coin_reject   out  1                      one-cycle pulse; coin presented that cycle not credited
//  sel_deny      out  1                      one-cycle pulse; credit short, id out of range, or sold out
//  credit        out  CREDIT_W               current credit
//  busy          out  1                      high in VEND and CHANGE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; credit 0. Reset mid-vend/mid-change aborts with no further pulses.
//  FSM states: IDLE (credit==0), CREDIT, VEND, CHANGE.
//   IDLE/CREDIT, coin!=0: credit += val(coin) at the next edge; IDLE->CREDIT.
//     If credit+val > MAX_CREDIT: coin_reject=1, credit unchanged.
//   CREDIT, sel_valid, sel_id < NUM_PRODUCTS, credit >= PRICES[sel_id]:
//     -> VEND; credit -= price.
//   Denied selection: sel_deny pulse; state and credit unchanged.
//   VEND: exactly 1 cycle; dispense=1, dispense_id=latched sel_id.
//     Next: CHANGE if credit>0, else IDLE.
//   CREDIT, cancel: -> CHANGE with full credit (no dispense).
//   CHANGE: each cycle emit largest coin with val <= credit; subtract it.
//     Go to IDLE the cycle credit reaches 0. Remainder unpayable by COIN1 is forfeited (credit forced 0).
//  Priority in one cycle: cancel > sel_valid > coin.
//   Coin arriving with an accepted select or cancel: coin_reject.
//  busy: coin -> coin_reject; sel_valid and cancel ignored (no deny).
//  Outputs registered; dispense appears 1 cycle after accepted select.
//  First change coin appears 1 cycle after dispense; a cancel refund starts 1 cycle after cancel.
// CONFIGURATION
//  STOCK_EN defined: per-product stock counters init STOCK_INIT.
//   Select of a product with stock 0 -> sel_deny. Each dispense decrements its counter (floor 0).
//   Adds output sold_out[NUM_PRODUCTS-1:0], registered, reset value all 0 (STOCK_INIT>0).
//  STOCK_EN undefined: unlimited stock; no sold_out port; no counters synthesised.
// STRUCTURE
//  Package vend_pkg: state_e enum {IDLE,CREDIT,VEND,CHANGE}; coin_e codes.
//   Also coin_value() function mapping code->value from the parameters.
//  Sub-module vend_change_gen: greedy coin selector.
//   Inputs remaining credit; outputs coin code and its value; purely combinational.
//   Instantiated once inside the CHANGE datapath.
// TESTING (default params)
//  coin 1,1,1 then sel_id=0 -> credit 15, dispense id 0, no change_coin, back to IDLE.
//  coin 3 (25), sel_id=0 -> dispense; change_coin=2 one cycle; credit 0.
//  coin 2 (10), sel_id=1 -> sel_deny, credit stays 10.
//   Then cancel -> change_coin=2, then IDLE.
//  Insert coin 3 x4 (100), then coin 1 -> coin_reject, credit 100.
//   sel_id=3 (30) -> change 25,25,10,10.
//  Same cycle cancel+sel_valid+coin, credit 20 -> cancel wins, coin_reject, refund 10,10.
//  Reset asserted during CHANGE -> next cycle change_coin=0, credit 0, busy 0.
//  STOCK_EN: buy product 0 three times, fourth select -> sel_deny; sold_out[0]=1.

Source files
------------

// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vend_pkg
// Description : Shared types and helpers for the multi-product vending
//               controller: FSM state encoding, coin codes and the
//               code-to-value mapping used by both the credit and change
//               datapaths.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    COIN_NONE = 2'd0,
    COIN_1    = 2'd1,
    COIN_2    = 2'd2,
    COIN_3    = 2'd3
  } coin_e;

  // Map a coin code onto its value; the denominations come from the
  // instantiating module's parameters so the mapping stays in one place.
  function automatic logic [31:0] coin_value(
    input logic [1:0]  code,
    input int unsigned v1,
    input int unsigned v2,
    input int unsigned v3
  );
    logic [31:0] val;
    val = 32'd0;
    if (code == COIN_1) val = 32'(v1);
    if (code == COIN_2) val = 32'(v2);
    if (code == COIN_3) val = 32'(v3);
    return val;
  endfunction

endpackage : vend_pkg
`default_nettype wire

// File: rtl/vend_change_gen.sv
`default_nettype none
// ============================================================================
// Module      : vend_change_gen
// Description : Greedy change selector. Given the credit still owed, returns
//               the code and value of the largest coin that does not exceed
//               it, or no coin when even the smallest denomination is too big.
//               Purely combinational. Denominations must be ordered
//               COIN1_VAL < COIN2_VAL < COIN3_VAL.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_change_gen
  import vend_pkg::*;
#(
  parameter int unsigned CREDIT_W  = 7,
  parameter int unsigned COIN1_VAL = 5,
  parameter int unsigned COIN2_VAL = 10,
  parameter int unsigned COIN3_VAL = 25
) (
  input  logic [CREDIT_W-1:0] i_credit,
  output logic [1:0]          o_coin,
  output logic [CREDIT_W-1:0] o_value
);

  logic [31:0] w_credit;

  assign w_credit = 32'(i_credit);

  // Largest-first coin choice for the remaining credit
  always_comb begin
    o_coin = COIN_NONE;
    if (w_credit >= COIN3_VAL) begin
      o_coin = COIN_3;
    end else if (w_credit >= COIN2_VAL) begin
      o_coin = COIN_2;
    end else if (w_credit >= COIN1_VAL) begin
      o_coin = COIN_1;
    end
  end

  // The chosen value never exceeds i_credit, so truncation is lossless
  assign o_value = CREDIT_W'(coin_value(o_coin, COIN1_VAL, COIN2_VAL, COIN3_VAL));

endmodule : vend_change_gen
`default_nettype wire

// File: rtl/vend_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : vend_machine_multi
// Description : Multi-product vending controller. Accumulates coin credit,
//               sells one of NUM_PRODUCTS items at per-product prices, and
//               pays change / refunds as a greedy coin stream, one coin per
//               cycle. All outputs are registered.
// Config      : define STOCK_EN to add per-product stock counters and the
//               o_sold_out output; otherwise stock is unlimited.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_machine_multi
  import vend_pkg::*;
#(
  parameter int unsigned               NUM_PRODUCTS = 4,
  parameter int unsigned               CREDIT_W     = 7,
  parameter int unsigned               MAX_CREDIT   = 100,
  parameter int unsigned               COIN1_VAL    = 5,
  parameter int unsigned               COIN2_VAL    = 10,
  parameter int unsigned               COIN3_VAL    = 25,
  parameter logic [8*NUM_PRODUCTS-1:0] PRICES       = {8'd30, 8'd25, 8'd20, 8'd15},
`ifdef STOCK_EN
  parameter int unsigned               STOCK_INIT   = 3,
`endif
  localparam int unsigned              ID_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          i_coin,
  input  logic                i_sel_valid,
  input  logic [ID_W-1:0]     i_sel_id,
  input  logic                i_cancel,
  output logic                o_dispense,
  output logic [ID_W-1:0]     o_dispense_id,
  output logic [1:0]          o_change_coin,
  output logic                o_coin_reject,
  output logic                o_sel_deny,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_busy
`ifdef STOCK_EN
  ,
  output logic [NUM_PRODUCTS-1:0] o_sold_out
`endif
);

  state_e              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_dispense, w_dispense_nxt;
  logic [ID_W-1:0]     r_dispense_id, w_dispense_id_nxt;
  logic [1:0]          r_change_coin, w_change_coin_nxt;
  logic                r_coin_reject, w_coin_reject_nxt;
  logic                r_sel_deny, w_sel_deny_nxt;
  logic                r_busy;

  logic                    w_accepting;
  logic                    w_cancel_go;
  logic                    w_sel_try;
  logic                    w_sel_ok;
  logic                    w_coin_add;
  logic                    w_payout;
  logic                    w_pay_coin;
  logic [31:0]             w_coin_val;
  logic [31:0]             w_sum;
  logic [7:0]              w_price;
  logic                    w_in_range;
  logic                    w_stock_ok;
  logic [NUM_PRODUCTS-1:0] w_stock_avail;
  logic [1:0]              w_gen_coin;
  logic [CREDIT_W-1:0]     w_gen_val;
  logic [CREDIT_W-1:0]     w_rem;

  // IDLE and CREDIT are the only states that take coins, selects and cancels
  assign w_accepting = (r_state == IDLE) || (r_state == CREDIT);
  assign w_cancel_go = w_accepting && i_cancel;
  assign w_sel_try   = w_accepting && i_sel_valid && !i_cancel;
  assign w_sel_ok    = w_sel_try && w_in_range && w_stock_ok &&
                       (32'(r_credit) >= 32'(w_price));

  assign w_coin_val  = coin_value(i_coin, COIN1_VAL, COIN2_VAL, COIN3_VAL);
  assign w_sum       = 32'(r_credit) + w_coin_val;
  // A coin is only credited when nothing of higher priority was accepted
  assign w_coin_add  = w_accepting && (i_coin != COIN_NONE) && !w_cancel_go &&
                       !w_sel_ok && (w_sum <= MAX_CREDIT);

  // Payout covers a fresh refund and every cycle of an ongoing change stream
  assign w_payout    = w_cancel_go ||
                       (((r_state == VEND) || (r_state == CHANGE)) && (r_credit != '0));
  assign w_pay_coin  = w_payout && (w_gen_coin != COIN_NONE);
  assign w_rem       = r_credit - w_gen_val;

  vend_change_gen #(
    .CREDIT_W  (CREDIT_W),
    .COIN1_VAL (COIN1_VAL),
    .COIN2_VAL (COIN2_VAL),
    .COIN3_VAL (COIN3_VAL)
  ) u_change_gen (
    .i_credit (r_credit),
    .o_coin   (w_gen_coin),
    .o_value  (w_gen_val)
  );

  // Decode the selected product: price, range check and stock availability
  always_comb begin
    w_price    = 8'd0;
    w_in_range = 1'b0;
    w_stock_ok = 1'b0;
    for (int p = 0; p < NUM_PRODUCTS; p++) begin
      if (i_sel_id == ID_W'(p)) begin
        w_price    = PRICES[p*8 +: 8];
        w_in_range = 1'b1;
        w_stock_ok = w_stock_avail[p];
      end
    end
  end

`ifdef STOCK_EN
  for (genvar p = 0; p < NUM_PRODUCTS; p++) begin : g_stock
    localparam int unsigned STOCK_W = (STOCK_INIT > 1) ? $clog2(STOCK_INIT + 1) : 1;
    logic [STOCK_W-1:0] r_cnt;
    logic               r_sold;

    // Count down this product's stock on each accepted sale, never below 0
    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt  <= STOCK_W'(STOCK_INIT);
        r_sold <= 1'b0;
      end else if (w_sel_ok && (i_sel_id == ID_W'(p)) && (r_cnt != '0)) begin
        r_cnt  <= r_cnt - 1'b1;
        r_sold <= (r_cnt == STOCK_W'(1));
      end
    end

    assign w_stock_avail[p] = (r_cnt != '0);
    assign o_sold_out[p]    = r_sold;
  end
`else
  assign w_stock_avail = '1;
`endif

  // Next-state selection; cancel beats select beats coin
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, CREDIT: begin
        if (w_cancel_go) begin
          w_state_nxt = w_pay_coin ? CHANGE : IDLE;
        end else if (w_sel_ok) begin
          w_state_nxt = VEND;
        end else if (w_coin_add) begin
          w_state_nxt = CREDIT;
        end
      end
      VEND, CHANGE: begin
        w_state_nxt = w_pay_coin ? CHANGE : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Next values of credit and of every registered output pulse
  always_comb begin
    w_credit_nxt      = r_credit;
    w_dispense_nxt    = 1'b0;
    w_dispense_id_nxt = '0;
    w_change_coin_nxt = COIN_NONE;
    w_coin_reject_nxt = (i_coin != COIN_NONE) && !w_coin_add;
    w_sel_deny_nxt    = w_sel_try && !w_sel_ok;
    if (w_payout) begin
      if (w_pay_coin) begin
        w_change_coin_nxt = w_gen_coin;
        // Anything smaller than the smallest coin cannot be paid back
        w_credit_nxt      = (32'(w_rem) < COIN1_VAL) ? '0 : w_rem;
      end else begin
        w_credit_nxt      = '0;
      end
    end else if (w_sel_ok) begin
      w_dispense_nxt    = 1'b1;
      w_dispense_id_nxt = i_sel_id;
      w_credit_nxt      = CREDIT_W'(32'(r_credit) - 32'(w_price));
    end else if (w_coin_add) begin
      w_credit_nxt      = CREDIT_W'(w_sum);
    end
  end

  // State, credit and output registers; reset aborts any vend or payout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_credit      <= '0;
      r_dispense    <= 1'b0;
      r_dispense_id <= '0;
      r_change_coin <= COIN_NONE;
      r_coin_reject <= 1'b0;
      r_sel_deny    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_dispense    <= w_dispense_nxt;
      r_dispense_id <= w_dispense_id_nxt;
      r_change_coin <= w_change_coin_nxt;
      r_coin_reject <= w_coin_reject_nxt;
      r_sel_deny    <= w_sel_deny_nxt;
      r_busy        <= (w_state_nxt == VEND) || (w_state_nxt == CHANGE);
    end
  end

  assign o_dispense    = r_dispense;
  assign o_dispense_id = r_dispense_id;
  assign o_change_coin = r_change_coin;
  assign o_coin_reject = r_coin_reject;
  assign o_sel_deny    = r_sel_deny;
  assign o_credit      = r_credit;
  assign o_busy        = r_busy;

endmodule : vend_machine_multi
`default_nettype wire

// File: tb/tb_vend_machine_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_machine_multi
// Description : Self-checking bench for vend_machine_multi (default
//               parameters). A transaction-level model turns each accepted
//               sale or refund into the full expected output session
//               (vend pulse, greedy coin stream, return to idle) and holds
//               it in a queue that is replayed cycle by cycle. Directed
//               scenarios are followed by randomized traffic. With STOCK_EN
//               defined the model also tracks stock and o_sold_out.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_machine_multi;

  localparam int NP   = 4;
  localparam int MAXC = 100;

  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic [1:0] coin      = 2'd0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_id    = 2'd0;
  logic       cancel    = 1'b0;
  logic       dispense;
  logic [1:0] dispense_id;
  logic [1:0] change_coin;
  logic       coin_reject;
  logic       sel_deny;
  logic [6:0] credit;
  logic       busy;
`ifdef STOCK_EN
  logic [NP-1:0] sold_out;
`endif

  vend_machine_multi dut (
    .clk           (clk),
    .rst           (rst),
    .i_coin        (coin),
    .i_sel_valid   (sel_valid),
    .i_sel_id      (sel_id),
    .i_cancel      (cancel),
    .o_dispense    (dispense),
    .o_dispense_id (dispense_id),
    .o_change_coin (change_coin),
    .o_coin_reject (coin_reject),
    .o_sel_deny    (sel_deny),
    .o_credit      (credit),
    .o_busy        (busy)
`ifdef STOCK_EN
    ,
    .o_sold_out    (sold_out)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit disp;
    int id;
    int chg;
    int credit;
    bit busy;
  } exp_t;

  exp_t q[$];
  int   m_credit;
  bit   m_busy;
  int   m_stock[NP];
  int   n_vec = 0;
  int   n_err = 0;
  int   price_tab[NP] = '{15, 20, 25, 30};
  int   coin_tab[4]   = '{0, 5, 10, 25};

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected output session for a sale (disp=1) or a refund of credit c
  function automatic void queue_session(int c, bit disp, int id, int price);
    exp_t e;
    int   code;
    if (disp) begin
      c = c - price;
      e = '{1'b1, id, 0, c, 1'b1};
      q.push_back(e);
    end
    while (c > 0) begin
      code = 0;
      for (int k = 3; k >= 1; k--) begin
        if (code == 0 && coin_tab[k] <= c) code = k;
      end
      if (code == 0) begin
        c = 0;
      end else begin
        c = c - coin_tab[code];
        if (c < coin_tab[1]) c = 0;
        e = '{1'b0, 0, code, c, 1'b1};
        q.push_back(e);
      end
    end
    e = '{1'b0, 0, 0, 0, 1'b0};
    q.push_back(e);
  endfunction

  task automatic step(input bit r, input logic [1:0] c, input bit sv,
                      input logic [1:0] sid, input bit cn);
    exp_t e;
    bit   rej;
    bit   deny;
    bit   sel_ok;
    rst = r; coin = c; sel_valid = sv; sel_id = sid; cancel = cn;
    rej = 1'b0; deny = 1'b0; sel_ok = 1'b0;
    e = '{1'b0, 0, 0, 0, 1'b0};
    if (r) begin
      q.delete();
      m_credit = 0;
      m_busy   = 1'b0;
      foreach (m_stock[i]) m_stock[i] = 3;
    end else if (m_busy) begin
      if (q.size() > 0) e = q.pop_front();
      rej = (c != 2'd0);
    end else begin
      if (cn) begin
        queue_session(m_credit, 1'b0, 0, 0);
      end else if (sv) begin
        if (m_credit >= price_tab[sid] && m_stock[sid] > 0) begin
          sel_ok = 1'b1;
`ifdef STOCK_EN
          m_stock[sid] = m_stock[sid] - 1;
`endif
          queue_session(m_credit, 1'b1, int'(sid), price_tab[sid]);
        end else begin
          deny = 1'b1;
        end
      end
      if (c != 2'd0) begin
        if (cn || sel_ok || (m_credit + coin_tab[c] > MAXC)) rej = 1'b1;
        else m_credit = m_credit + coin_tab[c];
      end
      if (q.size() > 0) e = q.pop_front();
      else e = '{1'b0, 0, 0, m_credit, 1'b0};
    end
    m_credit = e.credit;
    m_busy   = e.busy;
    @(posedge clk);
    #1;
    chk_eq("dispense", 32'(dispense), 32'(e.disp));
    if (e.disp) chk_eq("dispense_id", 32'(dispense_id), 32'(e.id));
    chk_eq("change_coin", 32'(change_coin), 32'(e.chg));
    chk_eq("coin_reject", 32'(coin_reject), 32'(rej));
    chk_eq("sel_deny", 32'(sel_deny), 32'(deny));
    chk_eq("credit", 32'(credit), 32'(e.credit));
    chk_eq("busy", 32'(busy), 32'(e.busy));
`ifdef STOCK_EN
    for (int p = 0; p < NP; p++) chk_eq("sold_out", 32'(sold_out[p]), 32'(m_stock[p] == 0));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    logic       r_r;
    logic [1:0] r_c;
    logic       r_sv;
    logic [1:0] r_sid;
    logic       r_cn;

    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);

    // Exact payment: 5+5+5 for product 0
    for (int i = 0; i < 3; i++) step(1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    idle(2);

    // 25 for product 0 -> one 10 change coin
    step(1'b0, 2'd3, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    idle(3);

    // Short credit denied, then refund
    step(1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
    idle(2);

    // Fill to the ceiling, overflow coin, then buy product 3 with change
    for (int i = 0; i < 4; i++) step(1'b0, 2'd3, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd1, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
    step(1'b0, 2'd1, 1'b1, 2'd0, 1'b1);
    idle(5);

    // Cancel + select + coin in one cycle at credit 20
    step(1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd1, 1'b1, 2'd0, 1'b1);
    idle(3);

    // Reset in the middle of a change stream
    step(1'b0, 2'd3, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd3, 1'b0, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
    step(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
    idle(2);

    // Four purchases of product 0 (stock runs out when STOCK_EN is set)
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 2'd3, 1'b0, 2'd0, 1'b0);
      step(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
      idle(3);
      step(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
      idle(3);
    end

    // Randomized traffic with occasional resets
    for (int i = 0; i < 4000; i++) begin
      r_r   = ($urandom_range(0, 299) == 0);
      r_c   = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      r_sv  = ($urandom_range(0, 5) == 0);
      r_sid = 2'($urandom_range(0, 3));
      r_cn  = ($urandom_range(0, 24) == 0);
      step(r_r, r_c, r_sv, r_sid, r_cn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_vend_machine_multi
`default_nettype wire
